// File: rtl/seq_pkg.sv
// Shared definitions for the seq_loader operand sequencer: state encoding,
// operand/result widths and the seq_hw weighting coefficients.
package seq_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int CNT_W = 4;

  localparam logic [RES_W-1:0] COEF_I1 = 16'd23;
  localparam logic [RES_W-1:0] COEF_I2 = 16'd18;
  localparam logic [RES_W-1:0] COEF_I3 = 16'd13;

  typedef enum logic [1:0] {
    LOAD0 = 2'd0,
    LOAD1 = 2'd1,
    LOAD2 = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  // Weighted sum seq_hw is expected to return, wrapped to the result width.
  function automatic logic [RES_W-1:0] seq_weighted_sum(
    input logic [OP_W-1:0] a,
    input logic [OP_W-1:0] b,
    input logic [OP_W-1:0] c
  );
    return (COEF_I1 * RES_W'(a)) + (COEF_I2 * RES_W'(b)) + (COEF_I3 * RES_W'(c));
  endfunction

endpackage

// File: rtl/seq_ref_calc.sv
// Reference arithmetic for the optional result checker: recomputes the
// expected seq_hw output from the operands currently driven downstream.
module seq_ref_calc
  import seq_pkg::*;
(
  input  logic [OP_W-1:0]  i_op1,
  input  logic [OP_W-1:0]  i_op2,
  input  logic [OP_W-1:0]  i_op3,
  output logic [RES_W-1:0] o_ref
);

  assign o_ref = seq_weighted_sum(i_op1, i_op2, i_op3);

endmodule

// File: rtl/seq_loader.sv
// Serial operand loader for seq_hw: collects three bytes, presents them as a
// stable triple for HOLD_CYCLES edges, then captures the result.
// Optional result checker enabled by macro SEQ_LOADER_CHECK_EN.
module seq_loader
  import seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [OP_W-1:0]  I1,
  output logic [OP_W-1:0]  I2,
  output logic [OP_W-1:0]  I3,
  input  logic [RES_W-1:0] O,
  output logic [RES_W-1:0] res,
  output logic             res_valid,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [OP_W-1:0]  r_s1;
  logic [OP_W-1:0]  r_s2;
  logic [OP_W-1:0]  r_i1;
  logic [OP_W-1:0]  r_i2;
  logic [OP_W-1:0]  r_i3;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_res;
  logic             r_res_valid;
  logic             w_din_ready;
  logic             w_accept;
  logic             w_load_s1;
  logic             w_load_s2;
  logic             w_load_ops;
  logic             w_capture;

  // Ready is gated by reset directly so nothing is accepted while it is held.
  assign w_din_ready = (r_state != HOLD) && !reset;
  assign w_accept    = w_din_ready && din_valid;

  // Next-state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_s1   = 1'b0;
    w_load_s2   = 1'b0;
    w_load_ops  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      LOAD0: begin
        if (w_accept) begin
          w_load_s1   = 1'b1;
          w_state_nxt = LOAD1;
        end else begin
          w_state_nxt = LOAD0;
        end
      end
      LOAD1: begin
        if (w_accept) begin
          w_load_s2   = 1'b1;
          w_state_nxt = LOAD2;
        end else begin
          w_state_nxt = LOAD1;
        end
      end
      LOAD2: begin
        if (w_accept) begin
          w_load_ops  = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = LOAD2;
        end
      end
      HOLD: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = LOAD0;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = LOAD0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shadow bytes, downstream operands, hold counter and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1        <= 8'd0;
      r_s2        <= 8'd0;
      r_i1        <= 8'd0;
      r_i2        <= 8'd0;
      r_i3        <= 8'd0;
      r_cnt       <= 4'd0;
      r_res       <= 16'd0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_load_s1) begin
        r_s1 <= din;
      end
      if (w_load_s2) begin
        r_s2 <= din;
      end
      // All three operands switch on one edge so seq_hw never sees a mix.
      if (w_load_ops) begin
        r_i1  <= r_s1;
        r_i2  <= r_s2;
        r_i3  <= din;
        r_cnt <= CNT_INIT;
      end else if ((r_state == HOLD) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_res <= O;
      end
      r_res_valid <= w_capture;
    end
  end

`ifdef SEQ_LOADER_CHECK_EN
  logic [RES_W-1:0] w_ref;
  logic             r_err;

  seq_ref_calc u_ref_calc (
    .i_op1 (r_i1),
    .i_op2 (r_i2),
    .i_op3 (r_i3),
    .o_ref (w_ref)
  );

  // Sticky mismatch flag, evaluated only on capture edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_capture && (w_ref != O)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign din_ready = w_din_ready;
  assign I1        = r_i1;
  assign I2        = r_i2;
  assign I3        = r_i3;
  assign res       = r_res;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_seq_loader.sv
// Self-checking bench for seq_loader: directed scenarios plus randomized
// triples checked against a result/latency model kept in the bench.
module tb_seq_loader;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  I1, I2, I3;
  logic [15:0] O;
  logic [15:0] res;
  logic        res_valid;
  logic        err;
  logic        force_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  long_pulse = 0;
  int  glitch = 0;
  logic        prev_rv;
  logic [15:0] prev_res;

  seq_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .I1        (I1),
    .I2        (I2),
    .I3        (I3),
    .O         (O),
    .res       (res),
    .res_valid (res_valid),
    .err       (err)
  );

  // Behavioural seq_hw stand-in; force_zero models a faulty downstream unit.
  assign O = force_zero ? 16'd0 : 16'(16'd23 * I1 + 16'd18 * I2 + 16'd13 * I3);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_valid) begin
      got_q.push_back('{val: res, cyc: cyc});
      if (prev_rv === 1'b1) long_pulse <= long_pulse + 1;
    end
    if (reset === 1'b0 && res_valid === 1'b0 && res !== prev_res) glitch <= glitch + 1;
    prev_rv  <= res_valid;
    prev_res <= res;
  end

  function automatic logic [15:0] model(input int a, input int b, input int c);
    return 16'((23 * a + 18 * b + 13 * c) % 65536);
  endfunction

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Presents one byte from a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, output int waited);
    waited = 0;
    din = b;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (din_ready !== 1'b1) begin
      $display("FAIL ready_timeout: din_ready=%b after %0d cycles, required 1", din_ready, waited);
      errors++;
    end
    @(negedge clk);
    last_acc = cyc;
    din_valid = 1'b0;
  endtask

  task automatic send_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input int gap, input bit zero_o);
    int w;
    send_byte(a, w);
    idle(gap);
    send_byte(b, w);
    idle(gap);
    send_byte(c, w);
    exp_q.push_back('{val: zero_o ? 16'd0 : model(a, b, c), cyc: last_acc + HOLD});
  endtask

  task automatic drain(input string name);
    int n = 0;
    ev_t g, e;
    while (got_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (HOLD + 2) @(negedge clk);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      $display("FAIL %s_count: got %0d results, required %0d", name, got_q.size(), exp_q.size());
      errors++;
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g.val !== e.val) begin
        $display("FAIL %s_res: got %0d, required %0d", name, g.val, e.val);
        errors++;
      end
      checks++;
      if (g.cyc != e.cyc) begin
        $display("FAIL %s_latency: capture at cycle %0d, required %0d", name, g.cyc, e.cyc);
        errors++;
      end
    end
    got_q.delete();
    exp_q.delete();
    checks++;
    if (long_pulse != 0) begin
      $display("FAIL %s_pulse_width: %0d multi-cycle res_valid pulses, required 0", name, long_pulse);
      errors++;
    end
    checks++;
    if (glitch != 0) begin
      $display("FAIL %s_res_hold: res changed %0d times without res_valid, required 0", name, glitch);
      errors++;
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({din_ready, I1, I2, I3, res, res_valid, err} !== 42'd0) begin
      $display("FAIL %s: ready=%b I=%0d/%0d/%0d res=%0d rv=%b err=%b, required all 0",
               name, din_ready, I1, I2, I3, res, res_valid, err);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din = 8'd0;
    din_valid = 1'b0;
    force_zero = 1'b0;
    repeat (3) @(negedge clk);
    din_valid = 1'b1;
    #1;
    check_all_zero("reset_state");
    din_valid = 1'b0;
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin
      $display("FAIL ready_after_reset: got %b, required 1", din_ready);
      errors++;
    end
  endtask

  task automatic test_all_max();
    send_triple(8'd255, 8'd255, 8'd255, 0, 1'b0);
    checks++;
    if (I1 !== 8'd255 || I2 !== 8'd255 || I3 !== 8'd255) begin
      $display("FAIL max_operands: got %0d/%0d/%0d, required 255/255/255", I1, I2, I3);
      errors++;
    end
    drain("all_max");
  endtask

  task automatic test_idle_gaps();
    int w;
    send_byte(8'd10, w);
    idle(3);
    checks++;
    if (I1 !== 8'd255 || I2 !== 8'd255 || I3 !== 8'd255) begin
      $display("FAIL gap_partial1: got %0d/%0d/%0d, required 255/255/255", I1, I2, I3);
      errors++;
    end
    send_byte(8'd20, w);
    idle(3);
    checks++;
    if (I1 !== 8'd255 || I2 !== 8'd255 || I3 !== 8'd255) begin
      $display("FAIL gap_partial2: got %0d/%0d/%0d, required 255/255/255", I1, I2, I3);
      errors++;
    end
    send_byte(8'd30, w);
    checks++;
    if (I1 !== 8'd10 || I2 !== 8'd20 || I3 !== 8'd30) begin
      $display("FAIL gap_operands: got %0d/%0d/%0d, required 10/20/30", I1, I2, I3);
      errors++;
    end
    exp_q.push_back('{val: model(10, 20, 30), cyc: last_acc + HOLD});
    drain("idle_gaps");
  endtask

  task automatic test_back_to_back();
    int w, acc_c;
    send_triple(8'd72, 8'd134, 8'd201, 0, 1'b0);
    acc_c = last_acc;
    send_byte(8'd1, w);
    checks++;
    if (w != HOLD) begin
      $display("FAIL b2b_ready_low: din_ready low for %0d cycles, required %0d", w, HOLD);
      errors++;
    end
    checks++;
    if (last_acc != acc_c + HOLD + 1) begin
      $display("FAIL b2b_first_accept: cycle %0d, required %0d", last_acc, acc_c + HOLD + 1);
      errors++;
    end
    send_byte(8'd2, w);
    send_byte(8'd3, w);
    exp_q.push_back('{val: model(1, 2, 3), cyc: last_acc + HOLD});
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    int w;
    send_byte(8'd255, w);
    send_byte(8'd255, w);
    send_byte(8'd255, w);
    idle(2);
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid_hold");
    @(negedge clk);
    #2;
    reset = 1'b0;
    idle(HOLD + 3);
    checks++;
    if (got_q.size() != 0) begin
      $display("FAIL reset_mid_no_pulse: got %0d results, required 0", got_q.size());
      errors++;
    end
    got_q.delete();
    send_triple(8'd10, 8'd20, 8'd30, 0, 1'b0);
    drain("after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      send_triple(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b0);
    end
    drain("random");
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL random_err: got %b, required 0", err);
      errors++;
    end
  endtask

  task automatic test_checker();
`ifdef SEQ_LOADER_CHECK_EN
    force_zero = 1'b1;
    send_triple(8'd10, 8'd20, 8'd30, 0, 1'b1);
    drain("checker_bad");
    force_zero = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      $display("FAIL checker_err_set: got %b, required 1", err);
      errors++;
    end
    send_triple(8'd1, 8'd2, 8'd3, 0, 1'b0);
    drain("checker_good");
    checks++;
    if (err !== 1'b1) begin
      $display("FAIL checker_err_sticky: got %b, required 1", err);
      errors++;
    end
`else
    force_zero = 1'b1;
    send_triple(8'd10, 8'd20, 8'd30, 0, 1'b1);
    drain("no_checker");
    force_zero = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL no_checker_err: got %b, required 0", err);
      errors++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_all_max();
    test_idle_gaps();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_checker();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
